// File: rtl/minesweeper_pkg.sv
// Shared minesweeper constants and the game_state encoding.
// The renderer decodes game_state with the same enum.
package minesweeper_pkg;

   localparam int GRID_W = 8;
   localparam int CELLS  = 64;
   localparam int IDX_W  = 6;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ARM      = 3'd1,
      ST_GEN_WAIT = 3'd2,
      ST_COUNT    = 3'd3,
      ST_PLAY     = 3'd4,
      ST_LOSE     = 3'd5,
      ST_WIN      = 3'd6
   } game_state_e;

endpackage

// File: rtl/minefield_controller_neighbour_count.sv
// Mine count over the up-to-8 neighbours of one cell.
// Neighbours off the board edge never wrap and contribute nothing.
module neighbour_count
   import minesweeper_pkg::*;
(
   input  logic [0:CELLS-1] map,
   input  logic [IDX_W-1:0] idx,
   output logic [3:0]       count
);

   always_comb begin
      int r;
      int c;
      r     = 0;
      c     = 0;
      count = '0;
      for (int dr = -1; dr <= 1; dr++) begin
         for (int dc = -1; dc <= 1; dc++) begin
            r = int'(idx[IDX_W-1:3]) + dr;
            c = int'(idx[2:0]) + dc;
            if ((dr != 0 || dc != 0) &&
                r >= 0 && r < GRID_W &&
                c >= 0 && c < GRID_W) begin
               count = count + 4'(map[6'(r * GRID_W + c)]);
            end
         end
      end
   end

endmodule

// File: rtl/minefield_controller.sv
// Game sequencer: arms the mine generator, latches and counts the map,
// then services reveals until a mine is hit or every safe cell is open.
module minefield_controller
   import minesweeper_pkg::*;
#(
   parameter int GEN_WAIT = 48
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             gen_enable,
   input  logic [0:CELLS-1] mine_array,
   input  logic             reveal_req,
   input  logic [IDX_W-1:0] reveal_idx,
   output logic             reveal_ack,
   output logic [3:0]       reveal_adj,
   output logic             reveal_mine,
   output logic [0:CELLS-1] revealed,
   output logic [0:CELLS-1] mines,
   output logic [6:0]       mine_total,
   output logic [2:0]       game_state
);

   localparam int WAIT_W = $clog2(GEN_WAIT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(GEN_WAIT - 1);

   game_state_e      state;
   game_state_e      state_nx;
   logic [WAIT_W-1:0] wait_cnt;
   logic [IDX_W-1:0] cnt_idx;
   logic [6:0]       rev_cnt;
   logic [3:0]       adj;
   logic             do_start;
   logic             do_reveal;
   logic             wait_step;
   logic             wait_done;
   logic             hit;
   logic             fresh;
   logic             win;

   neighbour_count u_nc (
      .map   (mines),
      .idx   (reveal_idx),
      .count (adj)
   );

   assign game_state = state;
   assign hit        = mines[reveal_idx];
   assign fresh      = !revealed[reveal_idx];
   assign win        = (rev_cnt + 7'd1) == (7'(CELLS) - mine_total);

   always_ff @(posedge clk) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      do_start  = 1'b0;
      do_reveal = 1'b0;
      wait_step = 1'b0;
      wait_done = 1'b0;
      unique case (state)
         ST_IDLE, ST_LOSE, ST_WIN: begin
            if (start) begin
               do_start = 1'b1;
               state_nx = ST_ARM;
            end
         end
         ST_ARM: begin
            wait_step = 1'b1;
            state_nx  = ST_GEN_WAIT;
         end
         ST_GEN_WAIT: begin
            // the ARM cycle is wait cycle 0, so the sample lands
            // GEN_WAIT cycles after gen_enable rises
            if (wait_cnt == WAIT_LAST) begin
               wait_done = 1'b1;
               state_nx  = ST_COUNT;
            end else begin
               wait_step = 1'b1;
            end
         end
         ST_COUNT: begin
            if (cnt_idx == IDX_W'(CELLS - 1)) state_nx = ST_PLAY;
         end
         ST_PLAY: begin
            if (start) begin
               do_start = 1'b1;
               state_nx = ST_ARM;
            end else if (reveal_req) begin
               do_reveal = 1'b1;
               if (hit)              state_nx = ST_LOSE;
               else if (fresh && win) state_nx = ST_WIN;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         gen_enable  <= 1'b0;
         reveal_ack  <= 1'b0;
         reveal_adj  <= '0;
         reveal_mine <= 1'b0;
         revealed    <= '0;
         mines       <= '0;
         mine_total  <= '0;
         rev_cnt     <= '0;
         wait_cnt    <= '0;
         cnt_idx     <= '0;
      end else begin
         gen_enable <= do_start;
         reveal_ack <= do_reveal;
         if (do_start) begin
            revealed   <= '0;
            mine_total <= '0;
            rev_cnt    <= '0;
            wait_cnt   <= '0;
         end
         if (wait_step) wait_cnt <= wait_cnt + WAIT_W'(1);
         if (wait_done) begin
            mines   <= mine_array;
            cnt_idx <= '0;
         end
         if (state == ST_COUNT) begin
            mine_total <= mine_total + 7'(mines[cnt_idx]);
            cnt_idx    <= cnt_idx + IDX_W'(1);
         end
         if (do_reveal) begin
            reveal_adj            <= adj;
            reveal_mine           <= hit;
            revealed[reveal_idx]  <= 1'b1;
            if (!hit && fresh) rev_cnt <= rev_cnt + 7'd1;
         end
      end
   end

endmodule

// File: tb/tb_minefield_controller.sv
// Bench for minefield_controller: directed scenarios plus random games
// checked against a cell-level game model.
module tb_minefield_controller;

   localparam int GEN_WAIT = 48;
   localparam int CELLS    = 64;

   logic        clk;
   logic        rst;
   logic        start;
   logic        gen_enable;
   logic [0:63] mine_array;
   logic        reveal_req;
   logic [5:0]  reveal_idx;
   logic        reveal_ack;
   logic [3:0]  reveal_adj;
   logic        reveal_mine;
   logic [0:63] revealed;
   logic [0:63] mines;
   logic [6:0]  mine_total;
   logic [2:0]  game_state;

   int vectors = 0;
   int errors  = 0;

   logic [0:63] mdl_mines;
   logic [0:63] mdl_rev;
   int          mdl_state;
   int          mdl_total;
   int          mdl_cnt;
   int          mdl_adj;
   bit          mdl_mine;

   minefield_controller #(.GEN_WAIT(GEN_WAIT)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .gen_enable  (gen_enable),
      .mine_array  (mine_array),
      .reveal_req  (reveal_req),
      .reveal_idx  (reveal_idx),
      .reveal_ack  (reveal_ack),
      .reveal_adj  (reveal_adj),
      .reveal_mine (reveal_mine),
      .revealed    (revealed),
      .mines       (mines),
      .mine_total  (mine_total),
      .game_state  (game_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int ref_adj(logic [0:63] m, int idx);
      int r;
      int c;
      int n;
      r = idx / 8;
      c = idx % 8;
      n = 0;
      for (int dr = -1; dr <= 1; dr++)
         for (int dc = -1; dc <= 1; dc++)
            if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < 8 &&
                c + dc >= 0 && c + dc < 8)
               n += int'(m[(r + dr) * 8 + c + dc]);
      return n;
   endfunction

   task automatic model_reveal(input int idx, output bit ack);
      ack = 1'b0;
      if (mdl_state == 4) begin
         ack      = 1'b1;
         mdl_adj  = ref_adj(mdl_mines, idx);
         mdl_mine = mdl_mines[idx];
         if (mdl_mine) begin
            mdl_rev[idx] = 1'b1;
            mdl_state    = 5;
         end else if (!mdl_rev[idx]) begin
            mdl_rev[idx] = 1'b1;
            mdl_cnt++;
            if (mdl_cnt == CELLS - mdl_total) mdl_state = 6;
         end
      end
   endtask

   // one request per cycle; each ack is checked the cycle after its request
   task automatic reveal_seq(input int q[$]);
      bit e_ack;
      int n;
      n     = q.size();
      e_ack = 1'b0;
      for (int i = 0; i <= n; i++) begin
         @(negedge clk);
         if (i > 0) begin
            vectors++;
            if (reveal_ack !== e_ack) begin
               errors++;
               $display("FAIL ack idx=%0d: got %b expected %b", q[i-1], reveal_ack, e_ack);
            end
            vectors++;
            if (reveal_adj !== 4'(mdl_adj)) begin
               errors++;
               $display("FAIL adj idx=%0d: got %0d expected %0d", q[i-1], reveal_adj, mdl_adj);
            end
            vectors++;
            if (reveal_mine !== mdl_mine) begin
               errors++;
               $display("FAIL mine idx=%0d: got %b expected %b", q[i-1], reveal_mine, mdl_mine);
            end
            vectors++;
            if (game_state !== 3'(mdl_state)) begin
               errors++;
               $display("FAIL state idx=%0d: got %0d expected %0d", q[i-1], game_state, mdl_state);
            end
            vectors++;
            if (revealed !== mdl_rev) begin
               errors++;
               $display("FAIL revealed idx=%0d: got %h expected %h", q[i-1], revealed, mdl_rev);
            end
         end
         if (i < n) begin
            reveal_req = 1'b1;
            reveal_idx = 6'(q[i]);
            model_reveal(q[i], e_ack);
         end else begin
            reveal_req = 1'b0;
         end
      end
   endtask

   task automatic reveal1(input int idx);
      int q[$];
      q.push_back(idx);
      reveal_seq(q);
   endtask

   // start pulse, optional start re-pulse at cycle poke_k, optional
   // same-cycle reveal; checks the whole arm/wait/count timeline
   task automatic start_game(input logic [0:63] m, input int poke_k, input bit collide);
      int exp_st;
      @(negedge clk);
      start      = 1'b1;
      mine_array = m;
      if (collide) begin
         reveal_req = 1'b1;
         reveal_idx = 6'd9;
      end
      for (int k = 1; k <= GEN_WAIT + CELLS + 1; k++) begin
         @(negedge clk);
         start      = 1'b0;
         reveal_req = 1'b0;
         exp_st = (k == 1) ? 1 : (k <= GEN_WAIT) ? 2 : (k <= GEN_WAIT + CELLS) ? 3 : 4;
         vectors++;
         if (game_state !== 3'(exp_st)) begin
            errors++;
            $display("FAIL start_state k=%0d: got %0d expected %0d", k, game_state, exp_st);
         end
         vectors++;
         if (gen_enable !== 1'(k == 1)) begin
            errors++;
            $display("FAIL gen_enable k=%0d: got %b expected %b", k, gen_enable, k == 1);
         end
         if (k == 1) begin
            vectors++;
            if (reveal_ack !== 1'b0 || revealed !== '0 || mine_total !== 7'd0) begin
               errors++;
               $display("FAIL arm_clear: ack=%b rev=%h total=%0d expected 0", reveal_ack, revealed, mine_total);
            end
         end
         if (k == GEN_WAIT + 1) begin
            vectors++;
            if (mines !== m) begin
               errors++;
               $display("FAIL mines_latch: got %h expected %h", mines, m);
            end
         end
         if (k == GEN_WAIT + CELLS + 1) begin
            vectors++;
            if (mine_total !== 7'($countones(m))) begin
               errors++;
               $display("FAIL mine_total: got %0d expected %0d", mine_total, $countones(m));
            end
         end
         start = 1'(k == poke_k);
      end
      start     = 1'b0;
      mdl_mines = m;
      mdl_rev   = '0;
      mdl_total = $countones(m);
      mdl_cnt   = 0;
      mdl_state = 4;
   endtask

   function automatic logic [0:63] map3(int a, int b, int c);
      logic [0:63] m;
      m = '0;
      if (a >= 0) m[a] = 1'b1;
      if (b >= 0) m[b] = 1'b1;
      if (c >= 0) m[c] = 1'b1;
      return m;
   endfunction

   task automatic test_reset();
      repeat (2) @(negedge clk);
      rst = 1'b1;
      vectors++;
      if (game_state !== 3'd0 || gen_enable !== 1'b0 || revealed !== '0 ||
          mine_total !== 7'd0 || reveal_ack !== 1'b0 || mines !== '0) begin
         errors++;
         $display("FAIL reset: state=%0d gen=%b rev=%h total=%0d expected all 0",
                  game_state, gen_enable, revealed, mine_total);
      end
      reveal1(5);
   endtask

   task automatic test_start_timing();
      start_game(map3(0, 1, 8), -1, 1'b0);
   endtask

   task automatic test_adjacency();
      reveal1(9);
      vectors++;
      if (reveal_adj !== 4'd3 || reveal_mine !== 1'b0) begin
         errors++;
         $display("FAIL adj_9: got adj=%0d mine=%b expected 3 0", reveal_adj, reveal_mine);
      end
      reveal1(63);
      vectors++;
      if (reveal_adj !== 4'd0) begin
         errors++;
         $display("FAIL adj_63: got %0d expected 0", reveal_adj);
      end
      start_game(map3(7, -1, -1), -1, 1'b0);
      reveal1(8);
      vectors++;
      if (reveal_adj !== 4'd0) begin
         errors++;
         $display("FAIL adj_nowrap: got %0d expected 0", reveal_adj);
      end
      start_game(map3(6, 14, 15), -1, 1'b0);
      reveal1(7);
      vectors++;
      if (reveal_adj !== 4'd3) begin
         errors++;
         $display("FAIL adj_corner: got %0d expected 3", reveal_adj);
      end
   endtask

   task automatic test_loss();
      start_game(map3(0, 1, 8), -1, 1'b0);
      reveal1(1);
      vectors++;
      if (reveal_mine !== 1'b1 || revealed[1] !== 1'b1 || game_state !== 3'd5) begin
         errors++;
         $display("FAIL loss: mine=%b rev1=%b state=%0d expected 1 1 5",
                  reveal_mine, revealed[1], game_state);
      end
      reveal1(3);
      start_game(map3(0, 1, 8), -1, 1'b0);
   endtask

   task automatic test_win_dup();
      int q[$];
      start_game(map3(0, -1, -1), -1, 1'b0);
      for (int i = 1; i < 64; i++) begin
         q.push_back(i);
         if (i == 20) q.push_back(5);
      end
      reveal_seq(q);
      vectors++;
      if (game_state !== 3'd6) begin
         errors++;
         $display("FAIL win: got state %0d expected 6", game_state);
      end
      reveal1(10);
   endtask

   task automatic test_back_to_back_priority();
      start_game(map3(0, 1, 8), -1, 1'b0);
      reveal1(9);
      start_game(map3(2, 30, 61), -1, 1'b1);
      start_game(map3(2, 30, 61), 20, 1'b0);
      start_game(map3(2, 30, 61), 80, 1'b0);
      reveal1(10);
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      start      = 1'b1;
      mine_array = map3(3, 4, 5);
      @(negedge clk);
      start = 1'b0;
      repeat (68) @(negedge clk);
      vectors++;
      if (game_state !== 3'd3) begin
         errors++;
         $display("FAIL pre_reset_state: got %0d expected 3", game_state);
      end
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      vectors++;
      if (game_state !== 3'd0 || mine_total !== 7'd0 || mines !== '0 ||
          revealed !== '0 || reveal_adj !== 4'd0 || reveal_mine !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: state=%0d total=%0d adj=%0d expected 0 0 0",
                  game_state, mine_total, reveal_adj);
      end
      mdl_state = 0;
      mdl_mines = '0;
      mdl_rev   = '0;
      mdl_total = 0;
      mdl_cnt   = 0;
      mdl_adj   = 0;
      mdl_mine  = 1'b0;
      reveal1(5);
   endtask

   task automatic full_clear(input logic [0:63] m);
      int q[$];
      int j;
      int t;
      start_game(m, -1, 1'b0);
      for (int i = 0; i < 64; i++)
         if (!m[i]) q.push_back(i);
      for (int i = q.size() - 1; i > 0; i--) begin
         j    = $urandom_range(0, i);
         t    = q[i];
         q[i] = q[j];
         q[j] = t;
      end
      q.insert($urandom_range(1, q.size() - 1), q[0]);
      q.push_back(int'($urandom_range(0, 63)));
      reveal_seq(q);
   endtask

   task automatic test_random();
      logic [0:63] m;
      int q[$];
      int dens;
      for (int g = 0; g < 4; g++) begin
         dens = int'($urandom_range(2, 25));
         for (int i = 0; i < 64; i++) m[i] = 1'($urandom_range(0, 99) < dens);
         start_game(m, -1, 1'b0);
         q.delete();
         for (int i = 0; i < 60; i++) q.push_back(int'($urandom_range(0, 63)));
         reveal_seq(q);
      end
      full_clear('0);
      m = '0;
      for (int i = 0; i < 3; i++) m[$urandom_range(0, 63)] = 1'b1;
      full_clear(m);
   endtask

   initial begin
      rst        = 1'b0;
      start      = 1'b0;
      reveal_req = 1'b0;
      reveal_idx = '0;
      mine_array = '0;
      mdl_mines  = '0;
      mdl_rev    = '0;
      mdl_state  = 0;
      mdl_total  = 0;
      mdl_cnt    = 0;
      mdl_adj    = 0;
      mdl_mine   = 1'b0;
      test_reset();
      test_start_timing();
      test_adjacency();
      test_loss();
      test_win_dup();
      test_back_to_back_priority();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
